// File: rtl/common_pkg.sv
// Shared RV32I decode types plus the combinational control and immediate decoders
// used by the decode/issue stage.
package common_pkg;

   localparam int XLEN_DEFAULT      = 32;
   localparam int REG_COUNT_DEFAULT = 32;

   typedef logic [31:0] instruction_t;

   typedef enum logic [2:0] {
      ENC_R = 3'd0,
      ENC_I = 3'd1,
      ENC_S = 3'd2,
      ENC_B = 3'd3,
      ENC_U = 3'd4,
      ENC_J = 3'd5
   } enc_t;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef struct packed {
      enc_t       enc;
      alu_op_t    alu_op;
      logic       alu_src_imm;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic [4:0] write_back_id;
   } control_t;

   // Immediate-form ALU ops never use bit 30 to select SUB (it is an immediate bit there).
   function automatic alu_op_t alu_from_funct(input logic [2:0] funct3, input logic alt,
                                              input logic is_imm);
      alu_op_t op;
      case (funct3)
         3'b000:  op = (alt && !is_imm) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic control_t decode_control(input instruction_t ins);
      control_t c;
      c        = '0;
      c.enc    = ENC_I;
      c.alu_op = ALU_ADD;
      case (ins[6:0])
         OP_LUI:    begin c.enc = ENC_U; c.alu_op = ALU_PASS_B; c.alu_src_imm = 1'b1; c.reg_write = 1'b1; end
         OP_AUIPC:  begin c.enc = ENC_U; c.alu_src_imm = 1'b1; c.reg_write = 1'b1; end
         OP_JAL:    begin c.enc = ENC_J; c.jump = 1'b1; c.reg_write = 1'b1; end
         OP_JALR:   begin c.enc = ENC_I; c.jump = 1'b1; c.reg_write = 1'b1; c.alu_src_imm = 1'b1; end
         OP_BRANCH: begin c.enc = ENC_B; c.branch = 1'b1; c.alu_op = ALU_SUB; end
         OP_LOAD:   begin c.enc = ENC_I; c.mem_read = 1'b1; c.reg_write = 1'b1; c.alu_src_imm = 1'b1; end
         OP_STORE:  begin c.enc = ENC_S; c.mem_write = 1'b1; c.alu_src_imm = 1'b1; end
         OP_IMM:    begin
            c.enc = ENC_I; c.reg_write = 1'b1; c.alu_src_imm = 1'b1;
            c.alu_op = alu_from_funct(ins[14:12], ins[30], 1'b1);
         end
         OP_REG:    begin
            c.enc = ENC_R; c.reg_write = 1'b1;
            c.alu_op = alu_from_funct(ins[14:12], ins[30], 1'b0);
         end
         default:   c.enc = ENC_I;
      endcase
      c.write_back_id = c.reg_write ? ins[11:7] : 5'd0;
      return c;
   endfunction

   // 32-bit immediate; callers sign-extend to the datapath width.
   function automatic logic [31:0] gen_imm(input instruction_t ins, input enc_t enc);
      logic [31:0] imm;
      case (enc)
         ENC_I:   imm = {{20{ins[31]}}, ins[31:20]};
         ENC_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         ENC_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         ENC_U:   imm = {ins[31:12], 12'h000};
         ENC_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: imm = 32'h0000_0000;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read one-write register file; register 0 reads as zero, and with BYPASS_EN
// a same-cycle write is forwarded to the read ports.
module regfile_bypass
   import common_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int REG_COUNT = REG_COUNT_DEFAULT,
   parameter int BYPASS_EN = 1,
   localparam int AW       = $clog2(REG_COUNT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_id,
   input  logic [XLEN-1:0] wr_data,
   input  logic [AW-1:0]   rd_id_a,
   input  logic [AW-1:0]   rd_id_b,
   output logic [XLEN-1:0] rd_data_a,
   output logic [XLEN-1:0] rd_data_b
);

   logic [XLEN-1:0]      regs_q [REG_COUNT];
   logic [REG_COUNT-1:0] wr_sel_d;
   logic                 fwd_a, fwd_b;

   always_comb begin
      wr_sel_d = '0;
      if (wr_en && (wr_id != {AW{1'b0}})) begin
         wr_sel_d[wr_id] = 1'b1;
      end else begin
         wr_sel_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < REG_COUNT; i++) begin
            if (wr_sel_d[i]) regs_q[i] <= wr_data;
         end
      end
   end

   assign fwd_a     = (BYPASS_EN != 0) && wr_en && (wr_id == rd_id_a);
   assign fwd_b     = (BYPASS_EN != 0) && wr_en && (wr_id == rd_id_b);
   assign rd_data_a = (rd_id_a == {AW{1'b0}}) ? '0 : (fwd_a ? wr_data : regs_q[rd_id_a]);
   assign rd_data_b = (rd_id_b == {AW{1'b0}}) ? '0 : (fwd_b ? wr_data : regs_q[rd_id_b]);

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes the fetched word, reads operands, detects load-use
// hazards and holds the ID/EX pipeline register with perf counters.
module decode_issue_stage
   import common_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int REG_COUNT = REG_COUNT_DEFAULT,
   parameter int CNT_W     = 16,
   parameter int BYPASS_EN = 1,
   localparam int AW       = $clog2(REG_COUNT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  instruction_t     instruction,
   input  logic [XLEN-1:0]  pc,
   input  logic             wb_en,
   input  logic [AW-1:0]    wb_id,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output control_t         out_control,
   output logic [XLEN-1:0]  out_imm,
   output logic [XLEN-1:0]  out_rs1_data,
   output logic [XLEN-1:0]  out_rs2_data,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   logic [4:0]       rs1_id, rs2_id;
   control_t         dec_ctrl;
   logic [31:0]      dec_imm;
   logic [XLEN-1:0]  rf_rd1, rf_rd2;
   logic             uses_rs1, uses_rs2, hazard, hold, wb_live;

   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_pc_q, out_pc_d;
   control_t         out_control_q, out_control_d;
   logic [XLEN-1:0]  out_imm_q, out_imm_d;
   logic [XLEN-1:0]  out_rs1_data_q, out_rs1_data_d;
   logic [XLEN-1:0]  out_rs2_data_q, out_rs2_data_d;
   logic [4:0]       out_rs1_q, out_rs1_d;
   logic [4:0]       out_rs2_q, out_rs2_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   regfile_bypass #(
      .XLEN      (XLEN),
      .REG_COUNT (REG_COUNT),
      .BYPASS_EN (BYPASS_EN)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wb_en),
      .wr_id     (wb_id),
      .wr_data   (wb_data),
      .rd_id_a   (AW'(rs1_id)),
      .rd_id_b   (AW'(rs2_id)),
      .rd_data_a (rf_rd1),
      .rd_data_b (rf_rd2)
   );

   // Load-use hazard only counts source fields the encoding actually reads.
   always_comb begin
      rs1_id   = instruction[19:15];
      rs2_id   = instruction[24:20];
      dec_ctrl = decode_control(instruction);
      dec_imm  = gen_imm(instruction, dec_ctrl.enc);
      uses_rs1 = (dec_ctrl.enc != ENC_U) && (dec_ctrl.enc != ENC_J);
      uses_rs2 = (dec_ctrl.enc == ENC_R) || (dec_ctrl.enc == ENC_S) || (dec_ctrl.enc == ENC_B);
      hazard   = out_valid_q && out_control_q.mem_read && (out_control_q.write_back_id != 5'd0) &&
                 ((uses_rs1 && (out_control_q.write_back_id == rs1_id)) ||
                  (uses_rs2 && (out_control_q.write_back_id == rs2_id)));
      in_ready = !rst && (flush || (!hazard && (!out_valid_q || out_ready)));
      hold     = out_valid_q && !out_ready && !flush;
      wb_live  = wb_en && (wb_id != {AW{1'b0}});
   end

   // A held instruction keeps picking up writebacks so it never issues stale operands.
   always_comb begin
      out_valid_d   = out_valid_q;
      out_pc_d      = out_pc_q;
      out_control_d = out_control_q;
      out_imm_d     = out_imm_q;
      out_rs1_d     = out_rs1_q;
      out_rs2_d     = out_rs2_q;
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (hold && wb_live && (AW'(out_rs1_q) == wb_id)) out_rs1_data_d = wb_data;
      else                                              out_rs1_data_d = out_rs1_data_q;
      if (hold && wb_live && (AW'(out_rs2_q) == wb_id)) out_rs2_data_d = wb_data;
      else                                              out_rs2_data_d = out_rs2_data_q;

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (hazard && out_ready) begin
         out_valid_d = 1'b0;
         // Only a real instruction waiting behind the load makes a bubble worth counting.
         if (in_valid && (stall_count_q != {CNT_W{1'b1}})) stall_count_d = stall_count_q + CNT_W'(1'b1);
         else                                               stall_count_d = stall_count_q;
      end else if (hold) begin
         out_valid_d = 1'b1;
      end else if (in_valid) begin
         out_valid_d    = 1'b1;
         out_pc_d       = pc;
         out_control_d  = dec_ctrl;
         out_imm_d      = XLEN'($signed(dec_imm));
         out_rs1_data_d = rf_rd1;
         out_rs2_data_d = rf_rd2;
         out_rs1_d      = rs1_id;
         out_rs2_d      = rs2_id;
      end else begin
         out_valid_d = 1'b0;
      end

      if (flush && (flush_count_q != {CNT_W{1'b1}})) flush_count_d = flush_count_q + CNT_W'(1'b1);
      else                                           flush_count_d = flush_count_q;
   end

   // ID/EX pipeline register and perf counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q    <= 1'b0;
         out_pc_q       <= '0;
         out_control_q  <= '0;
         out_imm_q      <= '0;
         out_rs1_data_q <= '0;
         out_rs2_data_q <= '0;
         out_rs1_q      <= 5'd0;
         out_rs2_q      <= 5'd0;
         stall_count_q  <= '0;
         flush_count_q  <= '0;
      end else begin
         out_valid_q    <= out_valid_d;
         out_pc_q       <= out_pc_d;
         out_control_q  <= out_control_d;
         out_imm_q      <= out_imm_d;
         out_rs1_data_q <= out_rs1_data_d;
         out_rs2_data_q <= out_rs2_data_d;
         out_rs1_q      <= out_rs1_d;
         out_rs2_q      <= out_rs2_d;
         stall_count_q  <= stall_count_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_pc       = out_pc_q;
   assign out_control  = out_control_q;
   assign out_imm      = out_imm_q;
   assign out_rs1_data = out_rs1_data_q;
   assign out_rs2_data = out_rs2_data_q;
   assign out_rs1      = out_rs1_q;
   assign out_rs2      = out_rs2_q;
   assign stall_count  = stall_count_q;
   assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an instruction-level reference model.
module tb_decode_issue_stage;
   import common_pkg::*;

   logic         clk, rst, in_valid, out_ready, flush, wb_en;
   instruction_t instruction;
   logic [31:0]  pc, wb_data;
   logic [4:0]   wb_id;

   logic         in_ready, out_valid;
   logic [31:0]  out_pc, out_imm, out_rs1_data, out_rs2_data;
   control_t     out_control;
   logic [4:0]   out_rs1, out_rs2;
   logic [15:0]  stall_count, flush_count;

   logic         nb_in_ready, nb_out_valid;
   logic [31:0]  nb_out_pc, nb_out_imm, nb_out_rs1_data, nb_out_rs2_data;
   control_t     nb_out_control;
   logic [4:0]   nb_out_rs1, nb_out_rs2;
   logic [1:0]   nb_stall_count, nb_flush_count;

   int n_checks = 0;
   int n_fail   = 0;

   decode_issue_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .pc(pc), .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_control(out_control), .out_imm(out_imm), .out_rs1_data(out_rs1_data),
      .out_rs2_data(out_rs2_data), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .stall_count(stall_count), .flush_count(flush_count));

   // Second instance: no write-through and a 2-bit counter so saturation is reachable.
   decode_issue_stage #(.BYPASS_EN(0), .CNT_W(2)) dut_nb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready),
      .instruction(instruction), .pc(pc), .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data),
      .flush(flush), .out_valid(nb_out_valid), .out_ready(out_ready), .out_pc(nb_out_pc),
      .out_control(nb_out_control), .out_imm(nb_out_imm), .out_rs1_data(nb_out_rs1_data),
      .out_rs2_data(nb_out_rs2_data), .out_rs1(nb_out_rs1), .out_rs2(nb_out_rs2),
      .stall_count(nb_stall_count), .flush_count(nb_flush_count));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: the instruction the stage should be presenting.
   logic        m_valid;
   logic [31:0] m_pc, m_imm, m_d1, m_d2;
   logic [4:0]  m_rs1, m_rs2;
   control_t    m_ctrl;
   int          m_stall, m_flush;
   logic [31:0] regs [32];
   alu_op_t     alu_tab [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] asr(input logic [31:0] x, input int n);
      logic signed [31:0] s;
      s = x;
      s = s >>> n;
      return s;
   endfunction

   function automatic logic reads_rs1(input logic [6:0] op);
      return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
   endfunction

   function automatic logic reads_rs2(input logic [6:0] op);
      return (op == 7'h33 || op == 7'h23 || op == 7'h63);
   endfunction

   function automatic control_t exp_ctrl(input logic [31:0] ins);
      control_t   c;
      logic [6:0] op;
      logic [2:0] f3;
      op = ins[6:0];
      f3 = ins[14:12];
      c = '0;
      c.reg_write   = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
      c.mem_read    = (op == 7'h03);
      c.mem_write   = (op == 7'h23);
      c.branch      = (op == 7'h63);
      c.jump        = (op == 7'h6F || op == 7'h67);
      c.alu_src_imm = op inside {7'h37, 7'h17, 7'h67, 7'h03, 7'h23, 7'h13};
      c.enc = (op == 7'h33) ? ENC_R : (op == 7'h23) ? ENC_S : (op == 7'h63) ? ENC_B :
              (op == 7'h37 || op == 7'h17) ? ENC_U : (op == 7'h6F) ? ENC_J : ENC_I;
      if (op == 7'h33 || op == 7'h13) begin
         c.alu_op = alu_tab[f3];
         if (f3 == 3'd0 && op == 7'h33 && ins[30]) c.alu_op = ALU_SUB;
         if (f3 == 3'd5 && ins[30]) c.alu_op = ALU_SRA;
      end else if (op == 7'h37) c.alu_op = ALU_PASS_B;
      else if (op == 7'h63) c.alu_op = ALU_SUB;
      else c.alu_op = ALU_ADD;
      c.write_back_id = c.reg_write ? ins[11:7] : 5'd0;
      return c;
   endfunction

   // Immediates rebuilt with arithmetic shifts and masks.
   function automatic logic [31:0] exp_imm(input logic [31:0] ins);
      case (ins[6:0])
         7'h33:                 return 32'h0;
         7'h23:                 return (asr(ins, 20) & ~32'h1F) | ((ins >> 7) & 32'h1F);
         7'h63:                 return (asr(ins, 19) & 32'hFFFFF000) | ((ins << 4) & 32'h800) |
                                       ((ins >> 20) & 32'h7E0) | ((ins >> 7) & 32'h1E);
         7'h37, 7'h17:          return ins & 32'hFFFFF000;
         7'h6F:                 return (asr(ins, 11) & 32'hFFF00000) | (ins & 32'h000FF000) |
                                       ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
         default:               return asr(ins, 20);
      endcase
   endfunction

   function automatic logic [31:0] rd_model(input logic [4:0] r);
      if (r == 5'd0) return 32'h0;
      if (wb_en && wb_id == r) return wb_data;
      return regs[r];
   endfunction

   function automatic logic model_hazard(input logic [31:0] ins);
      logic [4:0] d;
      d = m_ctrl.write_back_id;
      return m_valid && m_ctrl.mem_read && d != 5'd0 &&
             ((reads_rs1(ins[6:0]) && d == ins[19:15]) || (reads_rs2(ins[6:0]) && d == ins[24:20]));
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_pc = '0; m_imm = '0; m_d1 = '0; m_d2 = '0;
      m_rs1 = '0; m_rs2 = '0; m_ctrl = '0; m_stall = 0; m_flush = 0;
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
   endtask

   task automatic model_step();
      if (rst) begin
         model_reset();
         return;
      end
      if (flush) begin
         m_valid = 1'b0;
         if (m_flush < 65535) m_flush++;
      end else if (model_hazard(instruction) && out_ready) begin
         m_valid = 1'b0;
         if (in_valid && m_stall < 65535) m_stall++;
      end else if (m_valid && !out_ready) begin
         if (wb_en && wb_id != 5'd0 && wb_id == m_rs1) m_d1 = wb_data;
         if (wb_en && wb_id != 5'd0 && wb_id == m_rs2) m_d2 = wb_data;
      end else if (in_valid) begin
         m_valid = 1'b1;
         m_pc    = pc;
         m_ctrl  = exp_ctrl(instruction);
         m_imm   = exp_imm(instruction);
         m_rs1   = instruction[19:15];
         m_rs2   = instruction[24:20];
         m_d1    = rd_model(m_rs1);
         m_d2    = rd_model(m_rs2);
      end else begin
         m_valid = 1'b0;
      end
      if (wb_en && wb_id != 5'd0) regs[wb_id] = wb_data;
   endtask

   task automatic compare_all();
      chk("out_valid", out_valid, m_valid);
      chk("stall_count", stall_count, m_stall);
      chk("flush_count", flush_count, m_flush);
      if (m_valid) begin
         chk("out_pc", out_pc, m_pc);
         chk("out_control", out_control, m_ctrl);
         chk("out_imm", out_imm, m_imm);
         chk("out_rs1_data", out_rs1_data, m_d1);
         chk("out_rs2_data", out_rs2_data, m_d2);
         chk("out_rs1", out_rs1, m_rs1);
         chk("out_rs2", out_rs2, m_rs2);
      end
   endtask

   // Called at a falling edge with inputs applied; returns at the next falling edge.
   task automatic tick();
      #1;
      chk("in_ready", in_ready, (!rst && (flush || (!model_hazard(instruction) && (!m_valid || out_ready)))));
      model_step();
      @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic rdy, input logic fl, input logic we,
                        input logic [4:0] wid, input logic [31:0] wd);
      in_valid = v; instruction = ins; pc = p; out_ready = rdy; flush = fl;
      wb_en = we; wb_id = wid; wb_data = wd;
   endtask

   function automatic logic [31:0] rand_ins();
      logic [6:0]  ops [9];
      logic [31:0] ins;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
      ins = $urandom();
      ins[6:0] = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) != 0) begin
         ins[11:7]  = 5'($urandom_range(0, 4));
         ins[19:15] = 5'($urandom_range(0, 4));
         ins[24:20] = 5'($urandom_range(0, 4));
      end
      return ins;
   endfunction

   localparam logic [31:0] ADDI_X1 = 32'h0050_0093;  // addi x1,x0,5
   localparam logic [31:0] LW_X3   = 32'h0001_2183;  // lw   x3,0(x2)
   localparam logic [31:0] ADD_X4  = 32'h0011_8233;  // add  x4,x3,x1
   localparam logic [31:0] ADD_X6  = 32'h0052_8333;  // add  x6,x5,x5
   localparam logic [31:0] ADD_X7  = 32'h0004_03B3;  // add  x7,x8,x0

   initial begin
      alu_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      model_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      drive(1'b1, ADDI_X1, 32'h80, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_control", out_control, 18'h0);
      chk("rst_counters", {stall_count, flush_count}, 32'h0);

      rst = 1'b0;
      tick();
      chk("addi_valid", out_valid, 1'b1);
      chk("addi_imm", out_imm, 32'd5);
      chk("addi_rs1_data", out_rs1_data, 32'h0);
      chk("addi_reg_write", out_control.reg_write, 1'b1);

      drive(1'b1, LW_X3, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      drive(1'b1, ADD_X4, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      #1 chk("loaduse_in_ready", in_ready, 1'b0);
      tick();
      chk("bubble_valid", out_valid, 1'b0);
      chk("bubble_stall_count", stall_count, 16'd1);
      tick();
      chk("add_issue_valid", out_valid, 1'b1);
      chk("add_issue_pc", out_pc, 32'h104);

      drive(1'b1, ADD_X4, 32'h108, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      tick();
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_count_one", flush_count, 16'd1);
      drive(1'b0, ADD_X4, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      chk("flushed_add_gone", out_valid, 1'b0);

      drive(1'b1, ADD_X6, 32'h10C, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD);
      tick();
      chk("bypass_rs1", out_rs1_data, 32'hDEAD);
      chk("bypass_rs2", out_rs2_data, 32'hDEAD);
      chk("nobypass_rs1", nb_out_rs1_data, 32'h0);

      drive(1'b1, ADD_X7, 32'h110, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h1234);
      tick();
      chk("held_fwd_rs1", out_rs1_data, 32'h1234);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h5555);
      tick();
      chk("held_x0_rs2", out_rs2_data, 32'h0);
      chk("held_still_valid", out_valid, 1'b1);

      drive(1'b1, LW_X3, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      drive(1'b1, ADD_X4, 32'h204, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      chk("stall_hold_pc", out_pc, 32'h200);
      rst = 1'b1;
      #1;
      chk("midstall_rst_valid", out_valid, 1'b0);
      chk("midstall_rst_pc", out_pc, 32'h0);
      chk("midstall_rst_counts", {stall_count, flush_count}, 32'h0);
      chk("midstall_rst_in_ready", in_ready, 1'b0);
      tick();
      rst = 1'b0;
      drive(1'b1, ADDI_X1, 32'h300, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      chk("post_rst_issue", {out_valid, out_pc}, {1'b1, 32'h300});

      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
         tick();
      end
      chk("flush_count_five", flush_count, 16'd5);
      chk("flush_count_saturated", nb_flush_count, 2'd3);

      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         drive($urandom_range(0, 3) != 0, rand_ins(), $urandom(), $urandom_range(0, 9) < 7,
               $urandom_range(0, 11) == 0, $urandom_range(0, 4) < 2,
               5'($urandom_range(0, 4)), $urandom());
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_issue_stage.md
DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 Parameters (name, default, meaning): XLEN, 32, datapath width; REG_COUNT, 32, architectural registers; CNT_W, 16, perf-counter width; BYPASS_EN, 1, write-through regfile read enable.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, fetch offers an instruction.
- in_ready, out, 1, stage accepts this cycle.
- instruction, in, instruction_t, fetched word.
- pc, in, XLEN, fetched pc.
- wb_en, in, 1, writeback enable.
- wb_id, in, $clog2(REG_COUNT), writeback register.
- wb_data, in, XLEN, writeback value.
- flush, in, 1, branch-taken squash.
- out_valid, out, 1, ID/EX register holds a live instruction.
- out_ready, in, 1, execute accepts.
- out_pc, out, XLEN, registered pc.
- out_control, out, control_t, registered control.
- out_imm, out, XLEN, registered immediate.
- out_rs1_data, out, XLEN, registered operand 1.
- out_rs2_data, out, XLEN, registered operand 2.
- out_rs1, out, 5, registered source id 1.
- out_rs2, out, 5, registered source id 2.
- stall_count, out, CNT_W, load-use bubbles inserted.
- flush_count, out, CNT_W, flush cycles seen.

Function
REQ-003 Input transfer SHALL occur on in_valid && in_ready; output transfer SHALL occur on out_valid && out_ready.
REQ-004 Latency SHALL be one cycle: a transferred instruction SHALL appear on out_* the next cycle with out_valid=1.
REQ-005 in_ready SHALL equal flush || (!hazard && (!out_valid || out_ready)).
REQ-006 hazard SHALL be: out_valid && out_control.mem_read && out_control.write_back_id!=0 && the id matches the incoming rs1 (any type except U/J) or rs2 (R/S/B only).
REQ-007 On hazard with out_ready=1, the stage SHALL load a bubble (out_valid=0) next cycle and hold the incoming instruction.
REQ-008 On hazard with out_ready=0, the stage SHALL hold the output register unchanged.
REQ-009 On flush, out_valid SHALL be 0 next cycle and any instruction transferred in that cycle SHALL be discarded, regardless of out_ready or hazard.
REQ-010 Priority SHALL be: rst > flush > hazard > normal transfer.
REQ-011 While out_valid && !out_ready, a wb_en write to nonzero wb_id equal to out_rs1/out_rs2 SHALL update out_rs1_data/out_rs2_data next cycle.
REQ-012 Regfile reads of register 0 SHALL return 0, and writes to register 0 SHALL be ignored.
REQ-013 With BYPASS_EN=1, a read of register r in the cycle wb_en && wb_id==r (r!=0) SHALL return wb_data. With BYPASS_EN=0, the read SHALL return the old value.
REQ-014 Immediates SHALL be sign-extended to XLEN per encoding. U_TYPE places imm[31:12] and zero-extends the low bits.
REQ-015 stall_count SHALL increment once per bubble cycle of REQ-007. flush_count SHALL increment once per cycle flush=1. Both counters SHALL saturate at 2^CNT_W-1.

Reset
REQ-016 On rst assertion, asynchronously: out_valid=0; out_pc, out_imm, out_rs*_data, out_rs1, out_rs2=0; out_control=all-zero (no write, no mem access); counters=0; all registers=0.
REQ-017 in_ready SHALL be 0 while rst=1. The first transfer SHALL be possible on the first clk edge after deassertion.
REQ-018 Reset asserted mid-stall or mid-flush SHALL discard all in-flight state.

Structure
REQ-019 control_t, instruction_t, encoding and ALU enums, and XLEN/REG_COUNT defaults SHALL live in common_pkg.
REQ-020 The existing control and immediate-generator decoders SHALL be reused combinationally.
REQ-021 One new sub-module, regfile_bypass (2R1W, parametrised, write-through), SHALL be instantiated. Hazard logic, pipeline register and counters SHALL stay in this module.

Verification
REQ-022 Directed scenarios:
- ADDI x1,x0,5 with out_ready=1 -> next cycle out_valid=1, out_imm=5, out_rs1_data=0, out_control.reg_write=1.
- LW x3,0(x2) then ADD x4,x3,x1 -> exactly one bubble cycle, in_ready=0 that cycle, stall_count=1, ADD issues the following cycle.
- flush=1 while ADD is transferred -> next cycle out_valid=0, ADD never appears, flush_count=1.
- wb_en=1, wb_id=5, wb_data=0xDEAD while decoding ADD x6,x5,x5 -> out_rs1_data=out_rs2_data=0xDEAD (0 old value with BYPASS_EN=0).
- out_ready=0 holding ADD x7,x8,x0, then wb write x8=0x1234 -> held out_rs1_data becomes 0x1234; write to x0 leaves out_rs2_data=0.
- rst pulse during a stall -> all outputs 0 and counters 0; first instruction after release issues normally.
